// File: rtl/commit_monitor.sv
// ---------------------------------------------------------------------------
// commit_monitor
//   Watches the retire stream of a core under test. Every accepted commit is
//   counted and recorded as {pc, instr, seq} in a show-ahead trace FIFO. A
//   commit at end_pc_i ends the test. The monitor then drains the FIFO,
//   raises finish_o to request a memory flush, and halts once done_i reports
//   that the flush is complete.
//
// Optional feature:
//   COMMIT_MON_FLOW_CHECK_EN -- when defined, a control-flow checker is built
//   in. It expects pc+4 after any commit that is not a branch, JAL or JALR,
//   and it flags misaligned PCs. When undefined, error_o and err_pc_o are
//   tied to 0.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   commit_valid_i        one instruction retired this cycle
//   commit_pc_i           PC of the retired instruction
//   commit_instr_i        encoding of the retired instruction
//   end_pc_i              PC whose commit ends the test
//   done_i                memory flush complete
//   trace_valid_o         FIFO head valid
//   trace_ready_i         consumer accepts the head
//   trace_pc_o            head PC
//   trace_instr_o         head instruction
//   trace_seq_o           head sequence number
//   finish_o              flush request (registered)
//   halted_o              test complete (registered)
//   overflow_o            sticky: a trace record was dropped
//   cycle_count_o         cycles spent in RUN/DRAIN/WAIT_DONE (saturating)
//   instr_count_o         accepted commits (saturating)
//   error_o               sticky flow error
//   err_pc_o              PC of the first flow error
// ---------------------------------------------------------------------------
module commit_monitor #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  commit_valid_i,
  input  logic [ADDR_WIDTH-1:0] commit_pc_i,
  input  logic [31:0]           commit_instr_i,
  input  logic [ADDR_WIDTH-1:0] end_pc_i,
  input  logic                  done_i,
  output logic                  trace_valid_o,
  input  logic                  trace_ready_i,
  output logic [ADDR_WIDTH-1:0] trace_pc_o,
  output logic [31:0]           trace_instr_o,
  output logic [CNT_WIDTH-1:0]  trace_seq_o,
  output logic                  finish_o,
  output logic                  halted_o,
  output logic                  overflow_o,
  output logic [CNT_WIDTH-1:0]  cycle_count_o,
  output logic [CNT_WIDTH-1:0]  instr_count_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH-1:0] err_pc_o
);

  localparam int unsigned IDX_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W   = IDX_W + 1;
  localparam int unsigned ENTRY_W = ADDR_WIDTH + 32 + CNT_WIDTH;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    WAIT_DONE,
    HALTED
  } state_t;

  state_t state;

  // ------------------------------------------------------------------------
  // Trace FIFO
  // ------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               accept;
  logic               pop;
  logic               push;
  logic               end_hit;

  // The extra pointer MSB tells a full FIFO from an empty one when the
  // index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);

  assign accept  = commit_valid_i && (state == RUN);
  assign pop     = !fifo_empty && trace_ready_i;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still
  // lands when the consumer reads at the same time.
  assign push    = accept && (!fifo_full || pop);
  assign end_hit = accept && (commit_pc_i == end_pc_i);

  assign trace_valid_o = !fifo_empty;

  always_comb begin
    {trace_pc_o, trace_instr_o, trace_seq_o} = mem[rd_ptr[PTR_W-2:0]];
  end

  // Storage needs no reset: reset empties the FIFO by clearing the pointers,
  // so stale entries can never become visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[PTR_W-2:0]] <= {commit_pc_i, commit_instr_i, instr_count_o};
    end
  end

  // ------------------------------------------------------------------------
  // FSM, pointers, counters and status flags
  // ------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      finish_o      <= 1'b0;
      halted_o      <= 1'b0;
      overflow_o    <= 1'b0;
      cycle_count_o <= '0;
      instr_count_o <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      if (accept && fifo_full && !pop) begin
        overflow_o <= 1'b1;
      end

      if (accept && (instr_count_o != '1)) begin
        instr_count_o <= instr_count_o + CNT_WIDTH'(1);
      end

      if ((state != HALTED) && (cycle_count_o != '1)) begin
        cycle_count_o <= cycle_count_o + CNT_WIDTH'(1);
      end

      case (state)
        RUN: begin
          if (end_hit) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state    <= WAIT_DONE;
            finish_o <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (done_i) begin
            state    <= HALTED;
            finish_o <= 1'b0;
            halted_o <= 1'b1;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Optional control-flow checker
  // ------------------------------------------------------------------------
`ifdef COMMIT_MON_FLOW_CHECK_EN
  logic                  exp_armed;
  logic [ADDR_WIDTH-1:0] exp_pc;
  logic                  flow_err;
  logic                  is_ctrl;

  // Branch, JAL and JALR may go anywhere, so they leave no expectation.
  assign is_ctrl = (commit_instr_i[6:0] == 7'b1100011) ||
                   (commit_instr_i[6:0] == 7'b1101111) ||
                   (commit_instr_i[6:0] == 7'b1100111);

  assign flow_err = accept &&
                    ((exp_armed && (commit_pc_i != exp_pc)) ||
                     (commit_pc_i[1:0] != 2'b00));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_armed <= 1'b0;
      exp_pc    <= '0;
      error_o   <= 1'b0;
      err_pc_o  <= '0;
    end else begin
      if (accept) begin
        exp_armed <= !is_ctrl;
        exp_pc    <= commit_pc_i + ADDR_WIDTH'(4);
      end
      if (flow_err && !error_o) begin
        error_o  <= 1'b1;
        err_pc_o <= commit_pc_i;
      end
    end
  end
`else
  assign error_o  = 1'b0;
  assign err_pc_o = '0;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// ---------------------------------------------------------------------------
// tb_commit_monitor
//   Self-checking bench for commit_monitor (default parameters). Inputs are
//   driven on the falling edge. Each accepted commit pushes its expected
//   trace record into a scoreboard queue, and every head pop is compared
//   against the queue front. A small reference model tracks occupancy,
//   state, counters and overflow, and the registered outputs are compared
//   after each rising edge. Flow-checker scenarios follow
//   COMMIT_MON_FLOW_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_commit_monitor;

  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] seq;
  } rec_t;

  typedef enum int {M_RUN, M_DRAIN, M_WAIT, M_HALT} mstate_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        commit_valid_i = 1'b0;
  logic [31:0] commit_pc_i = '0;
  logic [31:0] commit_instr_i = '0;
  logic [31:0] end_pc_i = 32'hFFFF_FFF0;
  logic        done_i = 1'b0;
  logic        trace_valid_o;
  logic        trace_ready_i = 1'b0;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_instr_o;
  logic [31:0] trace_seq_o;
  logic        finish_o;
  logic        halted_o;
  logic        overflow_o;
  logic [31:0] cycle_count_o;
  logic [31:0] instr_count_o;
  logic        error_o;
  logic [31:0] err_pc_o;

  commit_monitor dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .commit_valid_i (commit_valid_i),
    .commit_pc_i    (commit_pc_i),
    .commit_instr_i (commit_instr_i),
    .end_pc_i       (end_pc_i),
    .done_i         (done_i),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready_i),
    .trace_pc_o     (trace_pc_o),
    .trace_instr_o  (trace_instr_o),
    .trace_seq_o    (trace_seq_o),
    .finish_o       (finish_o),
    .halted_o       (halted_o),
    .overflow_o     (overflow_o),
    .cycle_count_o  (cycle_count_o),
    .instr_count_o  (instr_count_o),
    .error_o        (error_o),
    .err_pc_o       (err_pc_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] ADD_I = 32'h0000_0033;
  localparam logic [31:0] BEQ_I = 32'h0000_0063;

  int      n_tests = 0;
  int      n_fail  = 0;
  rec_t    sb[$];
  mstate_t m_st    = M_RUN;
  logic    m_ovf   = 1'b0;
  int      m_icnt  = 0;
  int      m_ccnt  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_st   = M_RUN;
    m_ovf  = 1'b0;
    m_icnt = 0;
    m_ccnt = 0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    commit_valid_i = 1'b0;
    done_i         = 1'b0;
    trace_ready_i  = 1'b0;
    rst_i          = 1'b1;
    #1;
    check("rst_tvalid", 64'(trace_valid_o), 64'd0);
    check("rst_finish", 64'(finish_o), 64'd0);
    check("rst_halted", 64'(halted_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_icnt", 64'(instr_count_o), 64'd0);
    check("rst_ccnt", 64'(cycle_count_o), 64'd0);
    check("rst_err", 64'(error_o), 64'd0);
    check("rst_errpc", 64'(err_pc_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_clear();
  endtask

  // One clock cycle, entered and left on a falling edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic rdy, input logic dn);
    bit   emp;
    bit   pop;
    bit   acc;
    rec_t e;
    commit_valid_i = v;
    commit_pc_i    = pc;
    commit_instr_i = ins;
    trace_ready_i  = rdy;
    done_i         = dn;
    #1;
    emp = (sb.size() == 0);
    pop = !emp && rdy;
    acc = v && (m_st == M_RUN);
    check("tvalid", 64'(trace_valid_o), 64'(!emp));
    if (pop) begin
      e = sb.pop_front();
      check("tr_pc", 64'(trace_pc_o), 64'(e.pc));
      check("tr_instr", 64'(trace_instr_o), 64'(e.instr));
      check("tr_seq", 64'(trace_seq_o), 64'(e.seq));
    end
    if (acc) begin
      if (sb.size() < DEPTH) begin
        e.pc = pc; e.instr = ins; e.seq = 32'(m_icnt);
        sb.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
      m_icnt++;
    end
    if (m_st != M_HALT) m_ccnt++;
    case (m_st)
      M_RUN:   if (acc && pc == end_pc_i) m_st = M_DRAIN;
      M_DRAIN: if (emp) m_st = M_WAIT;
      M_WAIT:  if (dn) m_st = M_HALT;
      default: m_st = m_st;
    endcase
    @(negedge clk_i);
    commit_valid_i = 1'b0;
    done_i         = 1'b0;
    check("ovf", 64'(overflow_o), 64'(m_ovf));
    check("icnt", 64'(instr_count_o), 64'(m_icnt));
    check("ccnt", 64'(cycle_count_o), 64'(m_ccnt));
    check("finish", 64'(finish_o), 64'(m_st == M_WAIT));
    check("halted", 64'(halted_o), 64'(m_st == M_HALT));
  endtask

  // Reads the FIFO out; returns the number of pops seen (bounded).
  task automatic drain(output int n);
    n = 0;
    while (trace_valid_o && n < 4 * DEPTH) begin
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      n++;
    end
  endtask

  initial begin
    int          n;
    logic [31:0] frozen;

    @(negedge clk_i);
    do_reset();

    // Three sequential commits with the consumer always ready.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(4 * i), ADD_I, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("basic_icnt", 64'(instr_count_o), 64'd3);
    check("basic_empty", 64'(trace_valid_o), 64'd0);
    check("basic_err", 64'(error_o), 64'd0);

    // Overflow: ten commits with the consumer stalled.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'(4 * i), ADD_I, 1'b0, 1'b0);
      if (i == 7) check("ovf_at_8", 64'(overflow_o), 64'd0);
      if (i == 8) check("ovf_at_9", 64'(overflow_o), 64'd1);
    end
    check("ovf_icnt", 64'(instr_count_o), 64'd10);
    drain(n);
    check("ovf_drained", 64'(n), 64'd8);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(4 * i), ADD_I, 1'b0, 1'b0);
    cyc(1'b1, 32'd32, ADD_I, 1'b1, 1'b0);
    check("full_pp_ovf", 64'(overflow_o), 64'd0);
    drain(n);
    check("full_pp_occ", 64'(n), 64'd8);

    // End of test with entries pending.
    do_reset();
    end_pc_i = 32'd88;
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'd76 + 32'(4 * i), ADD_I, 1'b0, 1'b0);
    check("eot_finish0", 64'(finish_o), 64'd0);
    n = 0;
    while (m_st != M_WAIT && n < 20) begin
      cyc(1'b1, 32'd92, ADD_I, 1'b1, 1'b0);
      n++;
    end
    check("eot_reached_wait", 64'(m_st == M_WAIT), 64'd1);
    check("eot_icnt", 64'(instr_count_o), 64'd4);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'd96, ADD_I, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    check("eot_halted", 64'(halted_o), 64'd1);
    frozen = cycle_count_o;
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'd100, ADD_I, 1'b1, 1'b0);
    check("eot_ccnt_frozen", 64'(cycle_count_o), 64'(frozen));

    // Reset in WAIT_DONE.
    do_reset();
    cyc(1'b1, 32'd88, ADD_I, 1'b0, 1'b0);
    cyc(1'b1, 32'd92, ADD_I, 1'b0, 1'b0);
    n = 0;
    while (m_st != M_WAIT && n < 20) begin
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      n++;
    end
    check("mid_finish1", 64'(finish_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_finish0", 64'(finish_o), 64'd0);
    check("mid_tvalid", 64'(trace_valid_o), 64'd0);
    check("mid_icnt", 64'(instr_count_o), 64'd0);
    check("mid_ccnt", 64'(cycle_count_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_clear();
    end_pc_i = 32'hFFFF_FFF0;

    // Flow checker.
    do_reset();
    cyc(1'b1, 32'h10, ADD_I, 1'b1, 1'b0);
    cyc(1'b1, 32'h20, ADD_I, 1'b1, 1'b0);
    cyc(1'b1, 32'h40, ADD_I, 1'b1, 1'b0);
`ifdef COMMIT_MON_FLOW_CHECK_EN
    check("flow_err", 64'(error_o), 64'd1);
    check("flow_errpc", 64'(err_pc_o), 64'h20);
`else
    check("flow_err_off", 64'(error_o), 64'd0);
    check("flow_errpc_off", 64'(err_pc_o), 64'd0);
`endif
    do_reset();
    cyc(1'b1, 32'h10, BEQ_I, 1'b1, 1'b0);
    cyc(1'b1, 32'h40, ADD_I, 1'b1, 1'b0);
    check("flow_beq_ok", 64'(error_o), 64'd0);
    cyc(1'b1, 32'h46, ADD_I, 1'b1, 1'b0);
`ifdef COMMIT_MON_FLOW_CHECK_EN
    check("flow_mis_err", 64'(error_o), 64'd1);
    check("flow_mis_pc", 64'(err_pc_o), 64'h46);
`else
    check("flow_mis_off", 64'(error_o), 64'd0);
`endif
    drain(n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
